// File: rtl/simplerisc_apb_pkg.sv
// Shared definitions for the SimpleRisc APB master bridge.
//   - apb_state_e   : bridge FSM states
//   - SLOT_MSB/LSB  : address bits that select the APB slave
//   - DEF_*         : default bridge parameters
//   - ERR_RDATA     : read data returned on any error completion
package simplerisc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } apb_state_e;

    localparam int SLOT_MSB = 31;
    localparam int SLOT_LSB = 28;
    localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;

    localparam int DEF_NUM_SLAVES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of the core-side load/store port and the APB3 master bus.
//   master modport : used by apb_master_bridge
//   slave  modport : used by whatever drives the core side and models slaves
// Core side : transfer_abp, proc_addr, proc_write, proc_wdata -> bridge
//             proc_rdata, proc_ready, proc_err                 <- bridge
// APB side  : PADDR, PSEL, PENABLE, PWRITE, PWDATA             <- bridge
//             PRDATA, PREADY, PSLVERR                          -> bridge
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = simplerisc_apb_pkg::DEF_NUM_SLAVES
);
    logic                  transfer_abp;
    logic [31:0]           proc_addr;
    logic                  proc_write;
    logic [31:0]           proc_wdata;
    logic [31:0]           proc_rdata;
    logic                  proc_ready;
    logic                  proc_err;

    logic [31:0]           PADDR;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  transfer_abp, proc_addr, proc_write, proc_wdata,
        output proc_rdata, proc_ready, proc_err,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output transfer_abp, proc_addr, proc_write, proc_wdata,
        input  proc_rdata, proc_ready, proc_err,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave decoder: slot number -> one-hot PSEL.
//   slot_i : address slot field (proc_addr[SLOT_MSB:SLOT_LSB])
//   psel_o : one-hot select, all zero when the slot is out of range
//   oor_o  : slot has no slave behind it (decode error)
module apb_addr_decode
    import simplerisc_apb_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES
) (
    input  logic [SLOT_W-1:0]     slot_i,
    output logic [NUM_SLAVES-1:0] psel_o,
    output logic                  oor_o
);

    assign oor_o = (int'(slot_i) >= NUM_SLAVES);

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
        assign psel_o[i] = !oor_o && (slot_i == SLOT_W'(i));
    end

endmodule

// File: rtl/apb_master_bridge.sv
// SimpleRisc load/store port -> APB3 master bridge.
// Stalls the core through SETUP and ACCESS, then pulses proc_ready for one
// cycle with proc_err and (for loads) proc_rdata. Out-of-range slots complete
// in one cycle with an error and never touch the bus.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : apb_master_bridge_if.master (core side + APB master)
// Build option: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYCLES cycles; otherwise ACCESS waits for PREADY indefinitely.
module apb_master_bridge
    import simplerisc_apb_pkg::*;
#(
    parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus
);

    apb_state_e            state_q, state_d;
    logic [31:0]           paddr_q, paddr_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  penable_q, penable_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           rdata_c;
    logic                  ready_c, err_c;

    logic [NUM_SLAVES-1:0] dec_psel;
    logic                  dec_oor;
    logic                  tmo_expired;

    apb_addr_decode #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
        .slot_i (bus.proc_addr[SLOT_MSB:SLOT_LSB]),
        .psel_o (dec_psel),
        .oor_o  (dec_oor)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counter holds 0 outside ACCESS, so it reads 0 in the first ACCESS
    // cycle and TIMEOUT_CYCLES-1 in the last one allowed.
    assign tmo_expired = (state_q == ACCESS) &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (state_q == ACCESS && !tmo_expired) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_expired = 1'b0;
    // TIMEOUT_CYCLES only matters when the timeout is built.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        psel_d    = psel_q;
        rdata_d   = rdata_q;
        rdata_c   = rdata_q;
        ready_c   = 1'b0;
        err_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.transfer_abp) begin
                    if (dec_oor) begin
                        state_d = DERR;
                    end else begin
                        paddr_d  = bus.proc_addr;
                        pwdata_d = bus.proc_wdata;
                        pwrite_d = bus.proc_write;
                        psel_d   = dec_psel;
                        state_d  = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over a timeout expiring in the same cycle.
                if (bus.PREADY) begin
                    ready_c = 1'b1;
                    err_c   = bus.PSLVERR;
                    if (!pwrite_q) begin
                        rdata_c = bus.PSLVERR ? ERR_RDATA : bus.PRDATA;
                        // An errored read leaves the held value untouched.
                        if (!bus.PSLVERR) rdata_d = bus.PRDATA;
                    end
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else if (tmo_expired) begin
                    ready_c   = 1'b1;
                    err_c     = 1'b1;
                    rdata_c   = ERR_RDATA;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            DERR: begin
                ready_c = 1'b1;
                err_c   = 1'b1;
                rdata_c = ERR_RDATA;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PSEL       = psel_q;
    assign bus.proc_rdata = rdata_c;
    assign bus.proc_ready = ready_c;
    assign bus.proc_err   = err_c;

endmodule
